pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline hazard and control unit for the five-stage RV64 core. It produces the per-stage stall/flush controls consumed by the regF/regD/regE/regM/regW pipeline registers. It also sequences multi-cycle MDU operations with a launch/done handshake and a timeout watchdog, and keeps saturating stall and flush performance counters. Stage controls are combinational from inputs plus registered FSM state, so they act in the same cycle.

## Interface
- MDU_TIMEOUT, 64: maximum cycles in BUSY before the watchdog forces an exit (≥2).
- CNT_W, 32: width of the performance counters.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- decode_i_rs1, decode_i_rs2  in  5 each  source registers of the instruction in D.
- decode_i_rs1_used, decode_i_rs2_used  in  1 each  source actually read.
- regE_i_rd  in  5  destination register of the instruction in E.
- regE_i_reg_we  in  1  E instruction writes rd.
- regE_i_is_load  in  1  E instruction is a load.
- execute_i_mispredict  in  1  E resolved a branch/jump with next pc ≠ pre_pc.
- execute_i_mdu_start  in  1  E holds a multi-cycle mul/div.
- mdu_i_done  in  1  MDU result valid (honoured only in BUSY).
- memory_i_req  in  1  M holds a load/store.
- dmem_i_ready  in  1  data memory accepts/returns this cycle.
- ctrl_o_mdu_go  out  1  one-cycle MDU launch pulse.
- ctrl_o_regF_stall, ctrl_o_regD_stall, ctrl_o_regE_stall, ctrl_o_regM_stall  out  1 each.
- ctrl_o_regD_flush, ctrl_o_regE_flush, ctrl_o_regM_flush, ctrl_o_regW_flush  out  1 each.
- ctrl_o_mdu_timeout  out  1  sticky watchdog flag.
- ctrl_o_stall_cycles  out  CNT_W  cycles with regF stalled.
- ctrl_o_flush_cnt  out  CNT_W  mispredict flushes applied.

## Operation
- Derived terms:
  - mem_wait = memory_i_req & ~dmem_i_ready.
  - load_use = regE_i_is_load & regE_i_reg_we & (regE_i_rd≠0) & ((rs1_used & rs1==rd) | (rs2_used & rs2==rd)).
  - mdu_wait = (IDLE & execute_i_mdu_start) | (BUSY & ~mdu_i_done).
- Priority of stage controls (first match wins; any control not listed is 0):
  - 1. mem_wait: stall F, D, E, M; flush W.
  - 2. mdu_wait: stall F, D, E; flush M.
  - 3. execute_i_mispredict: flush D, flush E; F is not stalled, so the redirect PC loads.
  - 4. load_use: stall F, D; flush E.
  - 5. Otherwise all controls are 0.
- Mispredict outranks load_use because the D instruction is on the wrong path.
- A mispredict held under mem_wait persists, since E is frozen. It is applied, and counted, in the first cycle without mem_wait.
- FSM states:
  - IDLE → BUSY when execute_i_mdu_start & ~mem_wait. ctrl_o_mdu_go = 1 in that cycle only.
  - IDLE with execute_i_mdu_start & mem_wait: remain IDLE, no go.
  - BUSY → IDLE on mdu_i_done & ~mem_wait. E advances in the same cycle.
  - BUSY → HOLD on mdu_i_done & mem_wait. The result is held; mdu_wait = 0 in HOLD.
  - HOLD → IDLE when ~mem_wait. E advances in that cycle.
  - Watchdog: a counter clears on IDLE→BUSY and increments each BUSY cycle. If it reaches MDU_TIMEOUT−1 without done, the FSM goes to HOLD and sets ctrl_o_mdu_timeout. The flag is cleared only by rst.
- Counters saturate at all-ones:
  - ctrl_o_stall_cycles increments on each cycle with ctrl_o_regF_stall = 1.
  - ctrl_o_flush_cnt increments on each cycle where priority 3 is selected.
- Reset:
  - While rst is high, all stage controls and ctrl_o_mdu_go are forced to 0. The pipeline registers self-reset.
  - Reset state: FSM IDLE, watchdog 0, both counters 0, ctrl_o_mdu_timeout 0.
  - rst mid-BUSY/HOLD returns the FSM to IDLE next cycle with no go pulse.

## Timing
- Stage controls: combinational, zero latency from inputs and current state.
- FSM, watchdog, sticky flag and counters update on posedge clk; counter outputs reflect events one cycle late.
- MDU minimum occupancy of E is 2 cycles:
  - Launch cycle: stalled.
  - Done cycle: E advances, provided M is free.
- ctrl_o_mdu_go never asserts twice for one E instruction, because the FSM only re-enters IDLE in a cycle where E advances.

## Test plan
- Load-use: E = ld x5 (is_load, we, rd=5); D rs1=5 used → F/D stall=1, E flush=1, all else 0. With rd=0 → all 0.
- Mispredict + load_use in the same cycle → D flush=1, E flush=1, F stall=0; flush_cnt +1 next cycle.
- MDU: start=1 in IDLE → go=1, F/D/E stall, M flush. done 3 cycles later → stalls drop in the done cycle, FSM IDLE, go seen exactly once.
- MDU done during mem_wait: F/D/E/M stall, W flush; FSM enters HOLD. dmem_i_ready=1 → all stalls 0, FSM IDLE, no second go.
- Watchdog with MDU_TIMEOUT=4: no done → FSM in HOLD after 4 BUSY cycles, mdu_timeout=1, held until rst.
- Reset mid-BUSY with stall_cycles=7 → next cycle FSM IDLE, counters 0, all outputs 0; counter forced near all-ones saturates without wrap.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Hazard/control unit for the five-stage RV64 pipeline: per-stage stall/flush,
// multi-cycle MDU launch/done sequencing with a watchdog, and saturating perf counters.
module pipe_ctrl #(
  parameter int unsigned MDU_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       decode_i_rs1,
  input  logic [4:0]       decode_i_rs2,
  input  logic             decode_i_rs1_used,
  input  logic             decode_i_rs2_used,
  input  logic [4:0]       regE_i_rd,
  input  logic             regE_i_reg_we,
  input  logic             regE_i_is_load,
  input  logic             execute_i_mispredict,
  input  logic             execute_i_mdu_start,
  input  logic             mdu_i_done,
  input  logic             memory_i_req,
  input  logic             dmem_i_ready,
  output logic             ctrl_o_mdu_go,
  output logic             ctrl_o_regF_stall,
  output logic             ctrl_o_regD_stall,
  output logic             ctrl_o_regE_stall,
  output logic             ctrl_o_regM_stall,
  output logic             ctrl_o_regD_flush,
  output logic             ctrl_o_regE_flush,
  output logic             ctrl_o_regM_flush,
  output logic             ctrl_o_regW_flush,
  output logic             ctrl_o_mdu_timeout,
  output logic [CNT_W-1:0] ctrl_o_stall_cycles,
  output logic [CNT_W-1:0] ctrl_o_flush_cnt
);

  localparam int unsigned WD_W = $clog2(MDU_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic mem_wait;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic mdu_wait;
  logic sel_mispredict;

  // Hazard terms
  always_comb begin
    mem_wait = memory_i_req & ~dmem_i_ready;
    rs1_hit  = decode_i_rs1_used & (decode_i_rs1 == regE_i_rd);
    rs2_hit  = decode_i_rs2_used & (decode_i_rs2 == regE_i_rd);
    load_use = regE_i_is_load & regE_i_reg_we & (regE_i_rd != 5'd0) & (rs1_hit | rs2_hit);
    mdu_wait = ((state_q == S_IDLE) & execute_i_mdu_start) |
               ((state_q == S_BUSY) & ~mdu_i_done);
  end

  // State, watchdog, sticky flag and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wdog_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state: the FSM only returns to IDLE in a cycle where E advances
  always_comb begin
    state_d   = state_q;
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (execute_i_mdu_start && !mem_wait) begin
          state_d = S_BUSY;
          wdog_d  = '0;
        end
      end
      S_BUSY: begin
        if (mdu_i_done) begin
          state_d = mem_wait ? S_HOLD : S_IDLE;
        end else if (wdog_q == WD_W'(MDU_TIMEOUT - 1)) begin
          state_d   = S_HOLD;
          timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      S_HOLD: begin
        if (!mem_wait) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stage controls, first match wins
  always_comb begin
    ctrl_o_mdu_go     = 1'b0;
    ctrl_o_regF_stall = 1'b0;
    ctrl_o_regD_stall = 1'b0;
    ctrl_o_regE_stall = 1'b0;
    ctrl_o_regM_stall = 1'b0;
    ctrl_o_regD_flush = 1'b0;
    ctrl_o_regE_flush = 1'b0;
    ctrl_o_regM_flush = 1'b0;
    ctrl_o_regW_flush = 1'b0;
    sel_mispredict    = 1'b0;
    if (!rst) begin
      if (mem_wait) begin
        ctrl_o_regF_stall = 1'b1;
        ctrl_o_regD_stall = 1'b1;
        ctrl_o_regE_stall = 1'b1;
        ctrl_o_regM_stall = 1'b1;
        ctrl_o_regW_flush = 1'b1;
      end else if (mdu_wait) begin
        ctrl_o_regF_stall = 1'b1;
        ctrl_o_regD_stall = 1'b1;
        ctrl_o_regE_stall = 1'b1;
        ctrl_o_regM_flush = 1'b1;
        ctrl_o_mdu_go     = (state_q == S_IDLE);
      end else if (execute_i_mispredict) begin
        // F keeps running so the redirect PC is captured
        ctrl_o_regD_flush = 1'b1;
        ctrl_o_regE_flush = 1'b1;
        sel_mispredict    = 1'b1;
      end else if (load_use) begin
        ctrl_o_regF_stall = 1'b1;
        ctrl_o_regD_stall = 1'b1;
        ctrl_o_regE_flush = 1'b1;
      end
    end
  end

  // Saturating performance counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (ctrl_o_regF_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (sel_mispredict && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  assign ctrl_o_mdu_timeout  = timeout_q;
  assign ctrl_o_stall_cycles = stall_cnt_q;
  assign ctrl_o_flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic against a
// behavioural model of the hazard priorities, MDU sequencing and counters.
module tb_pipe_ctrl;

  localparam int unsigned TO  = 4;
  localparam int unsigned CW  = 8;
  localparam int          SAT = 255;

  localparam logic [8:0] C_NONE   = 9'b000000000;
  localparam logic [8:0] C_MEM    = 9'b111100010;
  localparam logic [8:0] C_LAUNCH = 9'b111000101;
  localparam logic [8:0] C_BUSY   = 9'b111000100;
  localparam logic [8:0] C_MP     = 9'b000011000;
  localparam logic [8:0] C_LU     = 9'b110001000;

  logic clk;
  logic rst;
  logic [4:0] rs1, rs2, e_rd;
  logic rs1_used, rs2_used, e_we, e_load, mp, start, done, mreq, dready;
  logic go, fst, dst, est, mst, dfl, efl, mfl, wfl, tout;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [8:0] ctl;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  bit m_busy  = 0;
  bit m_hold  = 0;
  bit m_to    = 0;
  int m_age   = 0;
  int m_stall = 0;
  int m_flush = 0;

  pipe_ctrl #(.MDU_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .decode_i_rs1         (rs1),
    .decode_i_rs2         (rs2),
    .decode_i_rs1_used    (rs1_used),
    .decode_i_rs2_used    (rs2_used),
    .regE_i_rd            (e_rd),
    .regE_i_reg_we        (e_we),
    .regE_i_is_load       (e_load),
    .execute_i_mispredict (mp),
    .execute_i_mdu_start  (start),
    .mdu_i_done           (done),
    .memory_i_req         (mreq),
    .dmem_i_ready         (dready),
    .ctrl_o_mdu_go        (go),
    .ctrl_o_regF_stall    (fst),
    .ctrl_o_regD_stall    (dst),
    .ctrl_o_regE_stall    (est),
    .ctrl_o_regM_stall    (mst),
    .ctrl_o_regD_flush    (dfl),
    .ctrl_o_regE_flush    (efl),
    .ctrl_o_regM_flush    (mfl),
    .ctrl_o_regW_flush    (wfl),
    .ctrl_o_mdu_timeout   (tout),
    .ctrl_o_stall_cycles  (stall_cnt),
    .ctrl_o_flush_cnt     (flush_cnt)
  );

  assign ctl = {fst, dst, est, mst, dfl, efl, mfl, wfl, go};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  // Expected stage controls from the priority rules and the model's MDU phase
  function automatic logic [8:0] model_ctl();
    logic mw, lu, idle, mdw;
    mw   = mreq & ~dready;
    lu   = e_load & e_we & (e_rd != 5'd0) &
           ((rs1_used & (rs1 == e_rd)) | (rs2_used & (rs2 == e_rd)));
    idle = !m_busy && !m_hold;
    mdw  = (idle & start) | (m_busy & ~done);
    if (rst)      return C_NONE;
    else if (mw)  return C_MEM;
    else if (mdw) return idle ? C_LAUNCH : C_BUSY;
    else if (mp)  return C_MP;
    else if (lu)  return C_LU;
    return C_NONE;
  endfunction

  // Advance model and one clock cycle; returns at the following negedge
  task automatic tick();
    logic [8:0] e;
    bit mw;
    e  = model_ctl();
    mw = mreq & ~dready;
    if (rst) begin
      m_busy = 0; m_hold = 0; m_to = 0; m_age = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (e[8] && m_stall < SAT) m_stall++;
      if (e[4] && m_flush < SAT) m_flush++;
      if (m_busy) begin
        if (done) begin
          m_busy = 0; m_hold = mw;
        end else if (m_age == TO - 1) begin
          m_busy = 0; m_hold = 1; m_to = 1;
        end else begin
          m_age++;
        end
      end else if (m_hold) begin
        if (!mw) m_hold = 0;
      end else if (start && !mw) begin
        m_busy = 1; m_age = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rs1 = 5'd0; rs2 = 5'd0; e_rd = 5'd0;
    rs1_used = 0; rs2_used = 0; e_we = 0; e_load = 0;
    mp = 0; start = 0; done = 0; mreq = 0; dready = 1;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; mreq = 1; dready = 0; start = 1; mp = 1;
    #1;
    n_tests++;
    if (ctl !== C_NONE) begin n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, C_NONE); end
    tick();
    #1;
    n_tests++;
    if ({stall_cnt, flush_cnt, tout} !== {8'd0, 8'd0, 1'b0}) begin
      n_fail++; $display("FAIL reset_regs: stall=%0d flush=%0d tout=%b want 0 0 0", stall_cnt, flush_cnt, tout);
    end
    rst = 0; start = 0; mp = 0;
    #1;
    n_tests++;
    if (ctl !== C_MEM) begin n_fail++; $display("FAIL reset_release_memwait: got %b want %b", ctl, C_MEM); end
    reset_dut();
  endtask

  task automatic test_load_use();
    reset_dut();
    e_load = 1; e_we = 1; e_rd = 5'd5; rs1 = 5'd5; rs1_used = 1;
    #1;
    n_tests++;
    if (ctl !== C_LU) begin n_fail++; $display("FAIL lu_rs1: got %b want %b", ctl, C_LU); end
    rs1_used = 0;
    #1;
    n_tests++;
    if (ctl !== C_NONE) begin n_fail++; $display("FAIL lu_rs1_unused: got %b want %b", ctl, C_NONE); end
    rs2 = 5'd5; rs2_used = 1;
    #1;
    n_tests++;
    if (ctl !== C_LU) begin n_fail++; $display("FAIL lu_rs2: got %b want %b", ctl, C_LU); end
    e_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; rs1_used = 1;
    #1;
    n_tests++;
    if (ctl !== C_NONE) begin n_fail++; $display("FAIL lu_x0: got %b want %b", ctl, C_NONE); end
    e_rd = 5'd9; rs1 = 5'd9; e_load = 0;
    #1;
    n_tests++;
    if (ctl !== C_NONE) begin n_fail++; $display("FAIL lu_not_load: got %b want %b", ctl, C_NONE); end
    idle_inputs();
  endtask

  task automatic test_mispredict();
    reset_dut();
    e_load = 1; e_we = 1; e_rd = 5'd5; rs1 = 5'd5; rs1_used = 1; mp = 1;
    #1;
    n_tests++;
    if (ctl !== C_MP) begin n_fail++; $display("FAIL mp_over_lu: got %b want %b", ctl, C_MP); end
    tick();
    mp = 0;
    #1;
    n_tests++;
    if (flush_cnt !== 8'd1) begin n_fail++; $display("FAIL mp_count: got %0d want 1", flush_cnt); end
    // Mispredict under mem_wait is held back and counted once released
    mp = 1; mreq = 1; dready = 0;
    #1;
    n_tests++;
    if (ctl !== C_MEM) begin n_fail++; $display("FAIL mp_under_memwait: got %b want %b", ctl, C_MEM); end
    tick();
    dready = 1;
    #1;
    n_tests++;
    if ({ctl, flush_cnt} !== {C_MP, 8'd1}) begin
      n_fail++; $display("FAIL mp_released: ctl=%b cnt=%0d want %b 1", ctl, flush_cnt, C_MP);
    end
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if (flush_cnt !== 8'd2) begin n_fail++; $display("FAIL mp_count2: got %0d want 2", flush_cnt); end
  endtask

  task automatic test_mdu();
    int gos;
    reset_dut();
    gos = 0;
    start = 1;
    #1;
    n_tests++;
    if (ctl !== C_LAUNCH) begin n_fail++; $display("FAIL mdu_launch: got %b want %b", ctl, C_LAUNCH); end
    gos += int'(go);
    tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++;
      if (ctl !== C_BUSY) begin n_fail++; $display("FAIL mdu_busy%0d: got %b want %b", i, ctl, C_BUSY); end
      gos += int'(go);
      tick();
    end
    done = 1;
    #1;
    n_tests++;
    if (ctl !== C_NONE) begin n_fail++; $display("FAIL mdu_done: got %b want %b", ctl, C_NONE); end
    gos += int'(go);
    tick();
    done = 0; start = 0;
    #1;
    n_tests++;
    if ({ctl, stall_cnt} !== {C_NONE, 8'd3}) begin
      n_fail++; $display("FAIL mdu_after: ctl=%b stall=%0d want %b 3", ctl, stall_cnt, C_NONE);
    end
    n_tests++;
    if (gos != 1) begin n_fail++; $display("FAIL mdu_go_once: got %0d want 1", gos); end
  endtask

  task automatic test_mdu_hold();
    reset_dut();
    start = 1;
    #1;
    n_tests++;
    if (ctl !== C_LAUNCH) begin n_fail++; $display("FAIL hold_launch: got %b want %b", ctl, C_LAUNCH); end
    tick();
    #1;
    n_tests++;
    if (ctl !== C_BUSY) begin n_fail++; $display("FAIL hold_busy: got %b want %b", ctl, C_BUSY); end
    tick();
    done = 1; mreq = 1; dready = 0;
    #1;
    n_tests++;
    if (ctl !== C_MEM) begin n_fail++; $display("FAIL hold_done_memwait: got %b want %b", ctl, C_MEM); end
    tick();
    done = 0;
    #1;
    n_tests++;
    if (ctl !== C_MEM) begin n_fail++; $display("FAIL hold_still_waiting: got %b want %b", ctl, C_MEM); end
    tick();
    dready = 1;
    #1;
    n_tests++;
    if (ctl !== C_NONE) begin n_fail++; $display("FAIL hold_release: got %b want %b", ctl, C_NONE); end
    tick();
    start = 0; mreq = 0;
    #1;
    n_tests++;
    if (ctl !== C_NONE) begin n_fail++; $display("FAIL hold_idle: got %b want %b", ctl, C_NONE); end
    start = 1;
    #1;
    n_tests++;
    if (ctl !== C_LAUNCH) begin n_fail++; $display("FAIL hold_relaunch: got %b want %b", ctl, C_LAUNCH); end
    idle_inputs();
  endtask

  task automatic test_watchdog();
    reset_dut();
    start = 1;
    #1;
    tick();
    for (int i = 0; i < int'(TO); i++) begin
      #1;
      n_tests++;
      if ({ctl, tout} !== {C_BUSY, 1'b0}) begin
        n_fail++; $display("FAIL wd_busy%0d: ctl=%b tout=%b want %b 0", i, ctl, tout, C_BUSY);
      end
      tick();
    end
    #1;
    n_tests++;
    if ({ctl, tout} !== {C_NONE, 1'b1}) begin
      n_fail++; $display("FAIL wd_hold: ctl=%b tout=%b want %b 1", ctl, tout, C_NONE);
    end
    tick();
    start = 0;
    repeat (5) tick();
    #1;
    n_tests++;
    if (tout !== 1'b1) begin n_fail++; $display("FAIL wd_sticky: got %b want 1", tout); end
    rst = 1;
    tick();
    rst = 0;
    #1;
    n_tests++;
    if (tout !== 1'b0) begin n_fail++; $display("FAIL wd_clear: got %b want 0", tout); end
  endtask

  task automatic test_reset_mid_busy();
    reset_dut();
    e_load = 1; e_we = 1; e_rd = 5'd7; rs1 = 5'd7; rs1_used = 1;
    repeat (3) tick();
    idle_inputs();
    start = 1;
    tick();
    repeat (3) tick();
    #1;
    n_tests++;
    if ({ctl, stall_cnt} !== {C_BUSY, 8'd7}) begin
      n_fail++; $display("FAIL rmb_pre: ctl=%b stall=%0d want %b 7", ctl, stall_cnt, C_BUSY);
    end
    rst = 1;
    #1;
    n_tests++;
    if (ctl !== C_NONE) begin n_fail++; $display("FAIL rmb_during: got %b want %b", ctl, C_NONE); end
    tick();
    rst = 0; start = 0;
    #1;
    n_tests++;
    if ({ctl, stall_cnt, flush_cnt, tout} !== {C_NONE, 8'd0, 8'd0, 1'b0}) begin
      n_fail++; $display("FAIL rmb_after: ctl=%b stall=%0d flush=%0d tout=%b", ctl, stall_cnt, flush_cnt, tout);
    end
    start = 1;
    #1;
    n_tests++;
    if (ctl !== C_LAUNCH) begin n_fail++; $display("FAIL rmb_idle: got %b want %b", ctl, C_LAUNCH); end
    idle_inputs();
  endtask

  task automatic test_saturation();
    reset_dut();
    mreq = 1; dready = 0;
    repeat (300) tick();
    #1;
    n_tests++;
    if (stall_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_stall: got %0d want 255", stall_cnt); end
    idle_inputs();
    mp = 1;
    repeat (300) tick();
    mp = 0;
    #1;
    n_tests++;
    if ({stall_cnt, flush_cnt} !== {8'd255, 8'd255}) begin
      n_fail++; $display("FAIL sat_flush: stall=%0d flush=%0d want 255 255", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_random();
    logic [8:0] e;
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      rs1      = 5'($urandom_range(0, 3));
      rs2      = 5'($urandom_range(0, 3));
      e_rd     = 5'($urandom_range(0, 3));
      rs1_used = 1'($urandom_range(0, 1));
      rs2_used = 1'($urandom_range(0, 1));
      e_we     = 1'($urandom_range(0, 1));
      e_load   = 1'($urandom_range(0, 1));
      mp       = ($urandom_range(0, 7) == 0);
      start    = ($urandom_range(0, 3) == 0);
      done     = ($urandom_range(0, 2) == 0);
      mreq     = 1'($urandom_range(0, 1));
      dready   = 1'($urandom_range(0, 1));
      #1;
      e = model_ctl();
      n_tests++;
      if ({ctl, stall_cnt, flush_cnt, tout} !== {e, 8'(m_stall), 8'(m_flush), m_to}) begin
        n_fail++;
        $display("FAIL rand_cycle%0d: ctl=%b stall=%0d flush=%0d tout=%b want %b %0d %0d %b",
                 i, ctl, stall_cnt, flush_cnt, tout, e, m_stall, m_flush, m_to);
      end
      tick();
    end
    idle_inputs();
    rst = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_mispredict();
    test_mdu();
    test_mdu_hold();
    test_watchdog();
    test_reset_mid_busy();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
